// File: rtl/gf_inv_if.sv
// Handshake and data bundle for the GF(2^m) inverter: request side (start, A)
// and result side (Inverse, done, busy, error, cycles).
interface gf_inv_if #(
    parameter int NUM_BITS = 163
);
    logic                start;
    logic [NUM_BITS:0]   A;
    logic [NUM_BITS:0]   Inverse;
    logic                done;
    logic                busy;
    logic                error;
    logic [9:0]          cycles;

    modport master (
        output start, A,
        input  Inverse, done, busy, error, cycles
    );

    modport slave (
        input  start, A,
        output Inverse, done, busy, error, cycles
    );
endinterface

// File: rtl/gf_inv.sv
// Multiplicative inverse in GF(2^NUM_BITS) by the binary extended Euclidean algorithm.
// Optional iteration counter on the cycles output is built when GF_INV_CYCLE_COUNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; the done pulse and the busy tail fall here
// LOAD   | validate the latched operand and seed u, v, g1, g2
// ITER   | one reduction step per cycle until u or v reaches 1
// DONE   | raise done for the next cycle and return to IDLE
module gf_inv #(
    parameter int                NUM_BITS = 163,
    parameter logic [NUM_BITS:0] POLY     = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9
) (
    input logic      clk,
    input logic      rst,
    gf_inv_if.slave  bus
);
    localparam int W  = NUM_BITS + 1;
    localparam int DW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   a_q, a_n;
    logic [W-1:0]   u, u_n;
    logic [W-1:0]   v, v_n;
    logic [W-1:0]   g1, g1_n;
    logic [W-1:0]   g2, g2_n;
    logic [W-1:0]   inv_q, inv_n;
    logic           err_q, err_n;
    logic           done_q, done_n;
    logic           busy_q, busy_n;

    // Divide by z modulo f: an odd g has f folded in first so the shift is exact.
    function automatic logic [W-1:0] halve(input logic [W-1:0] g);
        if (g[0])
            return (g ^ POLY) >> 1;
        else
            return g >> 1;
    endfunction

    function automatic logic [DW-1:0] deg(input logic [W-1:0] x);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i])
                d = DW'(i);
        end
        return d;
    endfunction

    always_comb begin
        state_n = state;
        a_n     = a_q;
        u_n     = u;
        v_n     = v;
        g1_n    = g1;
        g2_n    = g2;
        inv_n   = inv_q;
        err_n   = err_q;
        done_n  = 1'b0;
        busy_n  = busy_q;

        case (state)
            S_IDLE: begin
                // busy_q still set here means this is the done cycle; requests wait for it to pass
                if (bus.start && !busy_q) begin
                    a_n     = bus.A;
                    busy_n  = 1'b1;
                    state_n = S_LOAD;
                end else begin
                    busy_n  = 1'b0;
                end
            end

            S_LOAD: begin
                inv_n = '0;
                if (a_q == '0 || a_q[NUM_BITS]) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    err_n   = 1'b0;
                    u_n     = a_q;
                    v_n     = POLY;
                    g1_n    = W'(1);
                    g2_n    = '0;
                    state_n = S_ITER;
                end
            end

            S_ITER: begin
                if (u == W'(1)) begin
                    inv_n   = g1;
                    state_n = S_DONE;
                end else if (v == W'(1)) begin
                    inv_n   = g2;
                    state_n = S_DONE;
                end else if (!u[0]) begin
                    u_n  = u >> 1;
                    g1_n = halve(g1);
                end else if (!v[0]) begin
                    v_n  = v >> 1;
                    g2_n = halve(g2);
                end else if (deg(u) > deg(v)) begin
                    u_n  = u ^ v;
                    g1_n = g1 ^ g2;
                end else begin
                    v_n  = v ^ u;
                    g2_n = g2 ^ g1;
                end
            end

            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            u      <= '0;
            v      <= '0;
            g1     <= '0;
            g2     <= '0;
            inv_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            a_q    <= a_n;
            u      <= u_n;
            v      <= v_n;
            g1     <= g1_n;
            g2     <= g2_n;
            inv_q  <= inv_n;
            err_q  <= err_n;
            done_q <= done_n;
            busy_q <= busy_n;
        end
    end

    assign bus.Inverse = inv_q;
    assign bus.error   = err_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;

`ifdef GF_INV_CYCLE_COUNT_EN
    logic [9:0] cnt, cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cycles_q <= '0;
        end else begin
            case (state)
                S_LOAD:  cnt      <= '0;
                S_ITER:  cnt      <= cnt + 10'd1;
                S_DONE:  cycles_q <= cnt;
                default: ;
            endcase
        end
    end

    assign bus.cycles = cycles_q;
`else
    assign bus.cycles = '0;
`endif

endmodule
